// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 32-cycle iterative shift-add multiply and restoring divide,
// plus MTHI/MTLO writes. Results land in hi/lo only when the operation finishes.
module hilo_muldiv (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;   // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;  // multiplicand or divisor magnitude
    logic        is_div, neg_q, neg_r;

    logic        md_req, signed_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_comb begin
        md_req    = start && !op[2];
        busy      = (state != IDLE) || (md_req && state == IDLE);
        signed_op = !op[0];
        a_neg     = signed_op && a[31];
        b_neg     = signed_op && b[31];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_diff  = {acc[63:32], acc[31]} - {1'b0, opnd};
        prod      = neg_q ? -acc : acc;
        quo       = neg_q ? -acc[31:0] : acc[31:0];
        rem       = neg_r ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            acc         <= 64'd0;
            opnd        <= 32'd0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (md_req) begin
                            if (op[1] && b == 32'd0) begin
                                // divide by zero completes immediately, hi/lo untouched
                                done        <= 1'b1;
                                div_by_zero <= 1'b1;
                            end else begin
                                state  <= CALC;
                                cnt    <= 5'd0;
                                is_div <= op[1];
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                opnd   <= b_mag;
                                acc    <= {32'd0, a_mag};
                            end
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        if (!div_diff[32])
                            acc <= {div_diff[31:0], acc[30:0], 1'b1};
                        else
                            acc <= {acc[62:32], acc[31], acc[30:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= quo;
                        hi <= rem;
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised and directed bench for hilo_muldiv; expected results come from plain
// 64-bit arithmetic and are checked by a done-triggered scoreboard monitor.
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    hilo_muldiv dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the architectural result of each op from whole-number arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        exp_t        e;
        logic [63:0] p;
        longint      q, r;
        e.hi = cur_hi; e.lo = cur_lo; e.dbz = 1'b0;
        case (o)
            3'd0: begin
                q = longint'($signed(x)) * longint'($signed(y));
                p = 64'(q);
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    e.dbz = 1'b1;
                end else if (o == 3'd2) begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    p = 64'(q); e.lo = p[31:0];
                    p = 64'(r); e.hi = p[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_hi", 64'(hi), 64'(e.hi));
                check("sb_lo", 64'(lo), 64'(e.lo));
                check("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit inject_mthi);
        exp_t e;
        bit   md;
        int   cyc;
        md = (o < 3'd4);
        e  = model(o, x, y, m_hi, m_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 check("busy_req", 64'(busy), 64'(md));
        if (md) sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        if (o == 3'd4) begin
            m_hi = x;
            check("mthi", 64'(hi), 64'(x));
        end else if (o == 3'd5) begin
            m_lo = x;
            check("mtlo", 64'(lo), 64'(x));
        end else if (!md) begin
            check("nop_hilo", {hi, lo}, {m_hi, m_lo});
            check("nop_busy_done", 64'({busy, done}), 64'd0);
        end else if (e.dbz) begin
            @(negedge clk);
            check("dbz_flags", 64'({busy, done, div_by_zero}), 64'b011);
            @(negedge clk);
            check("dbz_done_once", 64'(done), 64'd0);
        end else begin
            cyc = 0;
            @(negedge clk);
            while (busy && cyc < 100) begin
                cyc++;
                if (inject_mthi && cyc == 5) begin
                    start = 1'b1; op = 3'd4; a = 32'hA5A5_A5A5;
                end else if (inject_mthi && cyc == 6) begin
                    start = 1'b0;
                    check("mid_hilo_stable", {hi, lo}, {m_hi, m_lo});
                end
                @(negedge clk);
            end
            check("busy_cycles", 64'(cyc), 64'd33);
            check("done_at_end", 64'(done), 64'd1);
            @(negedge clk);
            check("done_once", 64'(done), 64'd0);
            m_hi = e.hi; m_lo = e.lo;
        end
    endtask

    initial begin
        int dn;
        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        check("rst_outs", {hi, lo}, 64'd0);
        check("rst_flags", 64'({busy, done, div_by_zero}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_small", {hi, lo}, {32'd1, 32'd3});
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd4, 32'h11, 32'd0, 1'b0);
        do_op(3'd5, 32'h22, 32'd0, 1'b0);
        do_op(3'd3, 32'd5, 32'd0, 1'b0);
        check("dbz_hilo", {hi, lo}, {32'h11, 32'h22});
        do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        do_op(3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);

        // Abort a multiply mid-calculation.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hFFFF_0000; b = 32'h0001_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", 64'({busy, done, div_by_zero}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 1'b0);
            check("rand_hilo", {hi, lo}, {m_hi, m_lo});
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
